// File: rtl/throw_power_meter.sv
// Turns the held space key into a ping-pong charged throw: the power ramps between
// MIN_POWER and MAX_POWER while space is held, and releasing it fires a one-cycle trigger.
module throw_power_meter #(
  parameter int STEP_DIV     = 65000,
  parameter int STEP         = 1,
  parameter int MIN_POWER    = 16,
  parameter int MAX_POWER    = 255,
  parameter int COOLDOWN_CYC = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       space,
  output logic       throw_trigger,
  output logic [7:0] throw_power,
  output logic [7:0] power_level,
  output logic       charging
);

  localparam int PRE_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int COOL_W = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_DIV - 1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_CYC - 1);

  localparam logic [7:0] MIN8  = 8'(MIN_POWER);
  localparam logic [7:0] MAX8  = 8'(MAX_POWER);
  localparam logic [7:0] STEP8 = 8'(STEP);
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [8:0] MAX9  = 9'(MAX_POWER);
  localparam logic [8:0] DOWN_FLOOR9 = 9'(MIN_POWER + STEP);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_CHARGING = 2'd2;
  localparam logic [1:0] ST_COOLDOWN = 2'd3;

  logic [1:0]        state, state_n;
  logic [PRE_W-1:0]  prescaler, prescaler_n;
  logic [COOL_W-1:0] cool_cnt, cool_cnt_n;
  logic              dir_up, dir_up_n;
  logic [7:0]        power_n;
  logic [7:0]        throw_power_n;
  logic              trigger_n;
  logic              charging_n;

  logic [8:0]        up_sum;
  logic [7:0]        step_power;
  logic              step_dir_up;

  // Candidate value for the next ramp step; 9-bit sums keep the bound checks free of 8-bit wrap.
  always_comb begin
    up_sum      = {1'b0, power_level} + STEP9;
    step_power  = power_level;
    step_dir_up = dir_up;
    if (dir_up) begin
      if (up_sum >= MAX9) begin
        step_power  = MAX8;
        step_dir_up = 1'b0;
      end else begin
        step_power  = up_sum[7:0];
        step_dir_up = 1'b1;
      end
    end else begin
      if ({1'b0, power_level} <= DOWN_FLOOR9) begin
        step_power  = MIN8;
        step_dir_up = 1'b1;
      end else begin
        step_power  = power_level - STEP8;
        step_dir_up = 1'b0;
      end
    end
  end

  always_comb begin
    state_n       = state;
    prescaler_n   = prescaler;
    cool_cnt_n    = cool_cnt;
    dir_up_n      = dir_up;
    power_n       = power_level;
    throw_power_n = throw_power;
    trigger_n     = 1'b0;
    charging_n    = charging;

    case (state)
      // A key already held when the turn opens must be released before it counts.
      ST_IDLE: begin
        if (enable && !space) begin
          state_n = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (!enable) begin
          state_n = ST_IDLE;
        end else if (space) begin
          state_n     = ST_CHARGING;
          power_n     = MIN8;
          dir_up_n    = 1'b1;
          prescaler_n = '0;
          charging_n  = 1'b1;
        end
      end

      // Abort takes priority over release, and a release discards any step due this cycle.
      ST_CHARGING: begin
        if (!enable) begin
          state_n     = ST_IDLE;
          power_n     = 8'd0;
          charging_n  = 1'b0;
          prescaler_n = '0;
        end else if (!space) begin
          state_n       = ST_COOLDOWN;
          throw_power_n = power_level;
          trigger_n     = 1'b1;
          power_n       = 8'd0;
          charging_n    = 1'b0;
          prescaler_n   = '0;
          cool_cnt_n    = '0;
        end else if (prescaler == PRE_LAST) begin
          prescaler_n = '0;
          power_n     = step_power;
          dir_up_n    = step_dir_up;
        end else begin
          prescaler_n = prescaler + PRE_W'(1);
        end
      end

      ST_COOLDOWN: begin
        if (cool_cnt == COOL_LAST) begin
          state_n    = ST_IDLE;
          cool_cnt_n = '0;
        end else begin
          cool_cnt_n = cool_cnt + COOL_W'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      prescaler     <= '0;
      cool_cnt      <= '0;
      dir_up        <= 1'b1;
      power_level   <= 8'd0;
      throw_power   <= 8'd0;
      throw_trigger <= 1'b0;
      charging      <= 1'b0;
    end else begin
      state         <= state_n;
      prescaler     <= prescaler_n;
      cool_cnt      <= cool_cnt_n;
      dir_up        <= dir_up_n;
      power_level   <= power_n;
      throw_power   <= throw_power_n;
      throw_trigger <= trigger_n;
      charging      <= charging_n;
    end
  end

endmodule

// File: tb/tb_throw_power_meter.sv
// Self-checking bench for throw_power_meter: directed scenarios with literal pins plus
// randomized key/enable traffic, all compared every cycle against a behavioural model.
module tb_throw_power_meter;

  localparam int STEP_DIV     = 4;
  localparam int STEP         = 8;
  localparam int MIN_POWER    = 16;
  localparam int MAX_POWER    = 64;
  localparam int COOLDOWN_CYC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       space = 1'b0;
  logic       throw_trigger;
  logic [7:0] throw_power;
  logic [7:0] power_level;
  logic       charging;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Model: armed flag, cycles spent charging (-1 when not charging), cooldown cycles left.
  bit m_armed = 1'b0;
  int m_chg   = -1;
  int m_cool  = 0;
  int m_thr   = 0;
  bit m_trig  = 1'b0;

  throw_power_meter #(
    .STEP_DIV(STEP_DIV),
    .STEP(STEP),
    .MIN_POWER(MIN_POWER),
    .MAX_POWER(MAX_POWER),
    .COOLDOWN_CYC(COOLDOWN_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .space(space),
    .throw_trigger(throw_trigger),
    .throw_power(throw_power),
    .power_level(power_level),
    .charging(charging)
  );

  always #5 clk = ~clk;

  // Power after n ramp steps, walking the ping-pong from MIN_POWER.
  function automatic int pingpong(int n);
    int p = MIN_POWER;
    bit up = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (up) begin
        if (p + STEP >= MAX_POWER) begin p = MAX_POWER; up = 1'b0; end
        else p = p + STEP;
      end else begin
        if (p <= MIN_POWER + STEP) begin p = MIN_POWER; up = 1'b1; end
        else p = p - STEP;
      end
    end
    return p;
  endfunction

  function automatic int model_power();
    return (m_chg >= 0) ? pingpong(m_chg / STEP_DIV) : 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual != expected) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0d want %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit s, input int n);
    rst    = r;
    enable = e;
    space  = s;
    repeat (n) @(negedge clk);
  endtask

  // Advance the model on each edge, then compare every output shortly after it.
  always @(posedge clk) begin
    m_trig = 1'b0;
    if (rst) begin
      m_armed = 1'b0;
      m_chg   = -1;
      m_cool  = 0;
      m_thr   = 0;
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (m_chg >= 0) begin
      if (!enable) begin
        m_chg = -1;
      end else if (!space) begin
        m_thr  = model_power();
        m_trig = 1'b1;
        m_cool = COOLDOWN_CYC;
        m_chg  = -1;
      end else begin
        m_chg++;
      end
    end else if (m_armed) begin
      if (!enable) m_armed = 1'b0;
      else if (space) begin
        m_armed = 1'b0;
        m_chg   = 0;
      end
    end else if (enable && !space) begin
      m_armed = 1'b1;
    end
    #1;
    checkOutput("model_trigger", int'(throw_trigger), int'(m_trig));
    checkOutput("model_throw_power", int'(throw_power), m_thr);
    checkOutput("model_power_level", int'(power_level), model_power());
    checkOutput("model_charging", int'(charging), (m_chg >= 0) ? 1 : 0);
  end

  initial begin
    bit r, e, s;
    @(negedge clk);

    // Reset and a basic throw held for 13 sampled cycles: 16,24,32,40.
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkOutput("reset_trigger", int'(throw_trigger), 0);
    checkOutput("reset_throw_power", int'(throw_power), 0);
    checkOutput("reset_power_level", int'(power_level), 0);
    checkOutput("reset_charging", int'(charging), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    checkOutput("charge_start", int'(power_level), 16);
    applyStimulus(1'b0, 1'b1, 1'b1, 12);
    checkOutput("charge_40", int'(power_level), 40);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("release_trigger", int'(throw_trigger), 1);
    checkOutput("release_throw_power", int'(throw_power), 40);
    checkOutput("release_power_zero", int'(power_level), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("trigger_one_cycle", int'(throw_trigger), 0);

    // Key activity during cooldown is ignored.
    applyStimulus(1'b0, 1'b1, 1'b1, 3);
    checkOutput("cooldown_no_charge", int'(charging), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2);
    checkOutput("cooldown_no_trigger", int'(throw_trigger), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5);
    checkOutput("cooldown_keeps_power", int'(throw_power), 40);

    // Long hold: turn points at exactly 64 and 16.
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    checkOutput("long_start", int'(power_level), 16);
    applyStimulus(1'b0, 1'b1, 1'b1, 24);
    checkOutput("long_top", int'(power_level), 64);
    applyStimulus(1'b0, 1'b1, 1'b1, 4);
    checkOutput("long_after_top", int'(power_level), 56);
    applyStimulus(1'b0, 1'b1, 1'b1, 20);
    checkOutput("long_bottom", int'(power_level), 16);
    applyStimulus(1'b0, 1'b1, 1'b1, 4);
    checkOutput("long_after_bottom", int'(power_level), 24);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("long_throw_power", int'(throw_power), 24);

    // Abort at power 32 keeps the previous throw power.
    applyStimulus(1'b0, 1'b1, 1'b0, 11);
    applyStimulus(1'b0, 1'b1, 1'b1, 9);
    checkOutput("abort_pre_power", int'(power_level), 32);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("abort_trigger", int'(throw_trigger), 0);
    checkOutput("abort_power", int'(power_level), 0);
    checkOutput("abort_charging", int'(charging), 0);
    checkOutput("abort_throw_power", int'(throw_power), 24);

    // Space already held when enable rises is not a press.
    applyStimulus(1'b0, 1'b1, 1'b1, 5);
    checkOutput("prearm_no_charge", int'(charging), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    checkOutput("prearm_then_charge", int'(power_level), 16);

    // Enable and space both falling together: abort wins.
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("abort_wins_trigger", int'(throw_trigger), 0);
    checkOutput("abort_wins_throw_power", int'(throw_power), 24);

    // Reset mid-charge.
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 6);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    checkOutput("rst_mid_trigger", int'(throw_trigger), 0);
    checkOutput("rst_mid_throw_power", int'(throw_power), 0);
    checkOutput("rst_mid_power", int'(power_level), 0);
    checkOutput("rst_mid_charging", int'(charging), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3);
    checkOutput("rst_mid_stays_idle", int'(charging), 0);

    // Randomized traffic; the per-cycle model compare does the checking.
    e = 1'b1;
    s = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) e = ~e;
      if ($urandom_range(0, 11) == 0) s = ~s;
      applyStimulus(r, e, s, 1);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
